// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types, default sizes and width helper for the fetch queue
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch request/response sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    ACTIVE = 3'd3,
    DRAIN  = 3'd4
  } fetch_state_t;

  localparam int DEF_DEPTH_BYTES  = 128;
  localparam int DEF_BEAT_BYTES   = 8;
  localparam int DEF_LINE_BYTES   = 64;
  localparam int DEF_WINDOW_BYTES = 15;

  // Bits needed to index n items; never narrower than one bit
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_byte_ring.sv
`default_nettype none
// ============================================================================
//  Module   : byte_ring
//  Purpose  : Circular byte store with one masked beat-wide write port and
//             one wrap-around window-wide combinational read port
//  Revision : 1.0 - initial release
// ============================================================================
module byte_ring
  import fetch_pkg::*;
#(
  parameter int DEPTH_BYTES  = DEF_DEPTH_BYTES,
  parameter int BEAT_BYTES   = DEF_BEAT_BYTES,
  parameter int WINDOW_BYTES = DEF_WINDOW_BYTES,
  parameter int PTR_W        = width_of(DEF_DEPTH_BYTES)
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [PTR_W-1:0]          wr_ptr,
  input  logic [BEAT_BYTES-1:0]     wr_mask,
  input  logic [8*BEAT_BYTES-1:0]   wr_data,
  input  logic [PTR_W-1:0]          rd_ptr,
  output logic [8*WINDOW_BYTES-1:0] rd_data
);

  logic [7:0] mem [DEPTH_BYTES];

  // Masked beat write; byte j lands at ring address wr_ptr+j (natural wrap)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < BEAT_BYTES; j++) begin
        if (wr_mask[j]) begin
          mem[wr_ptr + PTR_W'(j)] <= wr_data[8*j +: 8];
        end
      end
    end
  end

  // Window read: byte i comes from rd_ptr+i, wrapping past the ring end
  for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_rd
    assign rd_data[8*i +: 8] = mem[rd_ptr + PTR_W'(i)];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-byte queue between the system bus and the decoder.
//             Issues line bursts from a running fetch RIP, fills a byte ring,
//             and presents a variable-consume decode window at the head.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH_BYTES  = DEF_DEPTH_BYTES,
  parameter int BEAT_BYTES   = DEF_BEAT_BYTES,
  parameter int LINE_BYTES   = DEF_LINE_BYTES,
  parameter int WINDOW_BYTES = DEF_WINDOW_BYTES
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [63:0]                       entry,
  input  logic                              redirect,
  input  logic [63:0]                       redirect_rip,
  output logic                              req_valid,
  output logic [63:0]                       req_addr,
  input  logic                              req_ack,
  input  logic                              resp_valid,
  input  logic [8*BEAT_BYTES-1:0]           resp_data,
  output logic                              resp_ack,
  output logic [8*WINDOW_BYTES-1:0]         dec_bytes,
  output logic [$clog2(WINDOW_BYTES+1)-1:0] dec_avail,
  output logic [63:0]                       dec_rip,
  input  logic [$clog2(WINDOW_BYTES+1)-1:0] dec_consume
);

  localparam int PTR_W  = $clog2(DEPTH_BYTES);
  localparam int CNT_W  = PTR_W + 1;
  localparam int AV_W   = $clog2(WINDOW_BYTES + 1);
  localparam int LOFF_W = $clog2(LINE_BYTES);
  localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
  localparam int BCNT_W = width_of(NBEATS);
  localparam int BB_W   = $clog2(BEAT_BYTES + 1);
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  fetch_state_t      state_q, state_d;
  logic              req_valid_q, req_valid_d;
  logic [63:0]       req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [63:0]       dec_rip_q, dec_rip_d;
  logic [63:0]       fetch_rip_q, fetch_rip_d;
  logic [LOFF_W-1:0] skip_q, skip_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [LOFF_W:0]         beat_off;
  logic [LOFF_W:0]         skip_ext;
  logic [BB_W-1:0]         first_byte;
  logic [BB_W-1:0]         n_bytes;
  logic [BEAT_BYTES-1:0]   wr_mask;
  logic [8*BEAT_BYTES-1:0] wr_data;
  logic                    beat_in;
  logic                    last_beat;
  logic                    wr_en;
  logic [BB_W-1:0]         written;
  logic [AV_W-1:0]         consumed;
  logic                    free_ok;

  assign beat_in   = resp_valid && ((state_q == WAIT) || (state_q == ACTIVE));
  assign wr_en     = beat_in && !redirect;
  assign last_beat = (beat_cnt_q == BCNT_W'(NBEATS - 1));
  assign written   = wr_en ? n_bytes : '0;
  assign free_ok   = (CNT_W'(DEPTH_BYTES) - count_q) >= CNT_W'(LINE_BYTES);

  assign dec_avail = (count_q >= CNT_W'(WINDOW_BYTES)) ? AV_W'(WINDOW_BYTES)
                                                       : AV_W'(count_q);
  // Over-consume is illegal upstream; clamp so the ring can never underflow
  assign consumed  = (dec_consume > dec_avail) ? dec_avail : dec_consume;

  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;
  assign resp_ack  = resp_valid;
  assign dec_rip   = dec_rip_q;

  // Beat slicing: drop bytes below the entry offset, pack the rest at byte 0
  always_comb begin
    beat_off   = (LOFF_W+1)'(beat_cnt_q) * (LOFF_W+1)'(BEAT_BYTES);
    skip_ext   = {1'b0, skip_q};
    first_byte = '0;
    n_bytes    = BB_W'(BEAT_BYTES);
    wr_mask    = '0;
    if (skip_ext >= beat_off + (LOFF_W+1)'(BEAT_BYTES)) begin
      first_byte = BB_W'(BEAT_BYTES);
      n_bytes    = '0;
    end else if (skip_ext > beat_off) begin
      first_byte = BB_W'(skip_ext - beat_off);
      n_bytes    = BB_W'(BEAT_BYTES) - first_byte;
    end
    wr_data = resp_data >> {first_byte, 3'b000};
    for (int j = 0; j < BEAT_BYTES; j++) begin
      wr_mask[j] = (BB_W'(j) < n_bytes);
    end
  end

  // Next-state: FSM, pointer/count bookkeeping, RIP tracking; redirect wins
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    count_d     = count_q + CNT_W'(written) - CNT_W'(consumed);
    rd_ptr_d    = rd_ptr_q + PTR_W'(consumed);
    wr_ptr_d    = wr_ptr_q + PTR_W'(written);
    dec_rip_d   = dec_rip_q + 64'(consumed);
    fetch_rip_d = fetch_rip_q;
    skip_d      = skip_q;
    beat_cnt_d  = beat_cnt_q;

    // Every beat of a burst is counted, including discarded stale ones
    if (resp_valid && ((state_q == WAIT) || (state_q == ACTIVE) || (state_q == DRAIN))) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + BCNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (free_ok) begin
          state_d     = REQ;
          req_valid_d = 1'b1;
          req_addr_d  = fetch_rip_q;
        end
      end
      REQ: begin
        if (req_ack) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end
      end
      WAIT, ACTIVE: begin
        if (resp_valid) begin
          if (last_beat) begin
            state_d     = IDLE;
            fetch_rip_d = fetch_rip_q + 64'(LINE_BYTES);
            skip_d      = '0;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      DRAIN: begin
        if (resp_valid && last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      count_d     = '0;
      rd_ptr_d    = wr_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      dec_rip_d   = redirect_rip;
      fetch_rip_d = redirect_rip & LINE_MASK;
      skip_d      = redirect_rip[LOFF_W-1:0];
      req_valid_d = 1'b0;
      req_addr_d  = req_addr_q;
      case (state_q)
        IDLE:    state_d = IDLE;
        // An ack in the same cycle means the bus owns the burst: drain it
        REQ:     state_d = req_ack ? DRAIN : IDLE;
        // Nothing left to drain if the old burst's final beat is arriving now
        default: state_d = (resp_valid && last_beat) ? IDLE : DRAIN;
      endcase
    end
  end

  // State register with asynchronous clear; RIPs reload from entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      dec_rip_q   <= entry;
      fetch_rip_q <= entry & LINE_MASK;
      skip_q      <= entry[LOFF_W-1:0];
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      dec_rip_q   <= dec_rip_d;
      fetch_rip_q <= fetch_rip_d;
      skip_q      <= skip_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  byte_ring #(
    .DEPTH_BYTES  (DEPTH_BYTES),
    .BEAT_BYTES   (BEAT_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES),
    .PTR_W        (PTR_W)
  ) u_ring (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr_q),
    .wr_mask (wr_mask),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (dec_bytes)
  );

  // Decode must never retire more than the window holds
  a_consume_le_avail: assert property (@(posedge clk) disable iff (!reset_n)
    dec_consume <= dec_avail);

  // Free-space gating must keep every accepted beat inside the ring
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    wr_en |-> ((CNT_W'(DEPTH_BYTES) - count_q) >= CNT_W'(n_bytes)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed self-checking bench for fetch_queue
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int BEAT = 8;
  localparam int WIN  = 15;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [63:0]     entry = 64'h1000;
  logic            redirect = 1'b0;
  logic [63:0]     redirect_rip = '0;
  logic            req_valid;
  logic [63:0]     req_addr;
  logic            req_ack = 1'b0;
  logic            resp_valid = 1'b0;
  logic [8*BEAT-1:0] resp_data = '0;
  logic            resp_ack;
  logic [8*WIN-1:0] dec_bytes;
  logic [3:0]      dec_avail;
  logic [63:0]     dec_rip;
  logic [3:0]      dec_consume = '0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .entry        (entry),
    .redirect     (redirect),
    .redirect_rip (redirect_rip),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ack      (req_ack),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_ack     (resp_ack),
    .dec_bytes    (dec_bytes),
    .dec_avail    (dec_avail),
    .dec_rip      (dec_rip),
    .dec_consume  (dec_consume)
  );

  // Window the decoder should see when the head sits at rip (bus data = addr low byte)
  function automatic logic [8*WIN-1:0] exp_window(input logic [63:0] rip);
    logic [8*WIN-1:0] w;
    for (int i = 0; i < WIN; i++) w[8*i +: 8] = 8'(rip + 64'(i));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset_n = 1'b0; entry = e; redirect = 1'b0; redirect_rip = '0;
    req_ack = 1'b0; resp_valid = 1'b0; resp_data = '0; dec_consume = '0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_req(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack_req();
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] line, input int k);
    resp_valid = 1'b1;
    for (int b = 0; b < BEAT; b++) resp_data[8*b +: 8] = 8'(line + 64'(k*BEAT + b));
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic consume(input int n);
    dec_consume = 4'(n);
    tick();
    dec_consume = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; entry = 64'h1000;
    repeat (2) tick();
    n_run++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    n_run++; if (req_addr !== 64'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h want 0", req_addr); end
    n_run++; if (dec_avail !== 4'd0) begin n_fail++; $display("FAIL reset_dec_avail: got %0d want 0", dec_avail); end
    n_run++; if (dec_rip !== 64'h1000) begin n_fail++; $display("FAIL reset_dec_rip: got %h want 1000", dec_rip); end
    n_run++; if (resp_ack !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ack: got %b want 0", resp_ack); end
    reset_n = 1'b1;
  endtask

  task automatic test_aligned();
    logic seen;
    wait_req(seen);
    n_run++; if (!seen || req_addr !== 64'h1000) begin n_fail++; $display("FAIL aligned_req: seen %b addr %h want 1000", seen, req_addr); end
    ack_req();
    n_run++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL aligned_req_drop: got %b want 0", req_valid); end
    n_run++; if (dec_avail !== 4'd0) begin n_fail++; $display("FAIL aligned_avail_pre: got %0d want 0", dec_avail); end
    resp_valid = 1'b1;
    #1;
    n_run++; if (resp_ack !== 1'b1) begin n_fail++; $display("FAIL aligned_resp_ack: got %b want 1", resp_ack); end
    send_beat(64'h1000, 0);
    n_run++; if (dec_avail !== 4'd8) begin n_fail++; $display("FAIL aligned_avail_b0: got %0d want 8", dec_avail); end
    send_beat(64'h1000, 1);
    n_run++; if (dec_avail !== 4'd15) begin n_fail++; $display("FAIL aligned_avail_b1: got %0d want 15", dec_avail); end
    n_run++; if (dec_bytes !== exp_window(64'h1000)) begin n_fail++; $display("FAIL aligned_window: got %h want %h", dec_bytes, exp_window(64'h1000)); end
    n_run++; if (dec_rip !== 64'h1000) begin n_fail++; $display("FAIL aligned_rip: got %h want 1000", dec_rip); end
    for (int k = 2; k < 8; k++) send_beat(64'h1000, k);
  endtask

  task automatic test_backpressure();
    logic seen;
    logic extra;
    wait_req(seen);
    n_run++; if (!seen || req_addr !== 64'h1040) begin n_fail++; $display("FAIL bp_req2: seen %b addr %h want 1040", seen, req_addr); end
    ack_req();
    for (int k = 0; k < 8; k++) send_beat(64'h1040, k);
    extra = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid !== 1'b0) extra = 1'b1;
      tick();
    end
    n_run++; if (extra !== 1'b0) begin n_fail++; $display("FAIL bp_no_third_req: got %b want 0", extra); end
    n_run++; if (dec_avail !== 4'd15) begin n_fail++; $display("FAIL bp_full_avail: got %0d want 15", dec_avail); end
    consume(15); consume(15); consume(15); consume(15); consume(4);
    n_run++; if (dec_rip !== 64'h1040) begin n_fail++; $display("FAIL bp_rip: got %h want 1040", dec_rip); end
    n_run++; if (dec_bytes[7:0] !== 8'h40) begin n_fail++; $display("FAIL bp_byte0: got %h want 40", dec_bytes[7:0]); end
    wait_req(seen);
    n_run++; if (!seen || req_addr !== 64'h1080) begin n_fail++; $display("FAIL bp_req3: seen %b addr %h want 1080", seen, req_addr); end
  endtask

  task automatic test_wrap();
    ack_req();
    for (int k = 0; k < 8; k++) send_beat(64'h1080, k);
    consume(15); consume(15); consume(15); consume(11);
    n_run++; if (dec_avail !== 4'd15) begin n_fail++; $display("FAIL wrap_avail: got %0d want 15", dec_avail); end
    n_run++; if (dec_rip !== 64'h1078) begin n_fail++; $display("FAIL wrap_rip: got %h want 1078", dec_rip); end
    n_run++; if (dec_bytes !== exp_window(64'h1078)) begin n_fail++; $display("FAIL wrap_window: got %h want %h", dec_bytes, exp_window(64'h1078)); end
    consume(15);
    n_run++; if (dec_rip !== 64'h1087) begin n_fail++; $display("FAIL wrap_rip2: got %h want 1087", dec_rip); end
    n_run++; if (dec_bytes !== exp_window(64'h1087)) begin n_fail++; $display("FAIL wrap_window2: got %h want %h", dec_bytes, exp_window(64'h1087)); end
  endtask

  task automatic test_redirect();
    logic seen;
    logic leak;
    do_reset(64'h1000);
    wait_req(seen);
    n_run++; if (!seen || req_addr !== 64'h1000) begin n_fail++; $display("FAIL redir_req: seen %b addr %h want 1000", seen, req_addr); end
    ack_req();
    for (int k = 0; k < 4; k++) send_beat(64'h1000, k);
    redirect = 1'b1; redirect_rip = 64'h2008;
    tick();
    redirect = 1'b0;
    n_run++; if (dec_avail !== 4'd0) begin n_fail++; $display("FAIL redir_avail: got %0d want 0", dec_avail); end
    n_run++; if (dec_rip !== 64'h2008) begin n_fail++; $display("FAIL redir_rip: got %h want 2008", dec_rip); end
    leak = 1'b0;
    for (int k = 4; k < 8; k++) begin
      send_beat(64'h1000, k);
      if (dec_avail !== 4'd0 || req_valid !== 1'b0) leak = 1'b1;
    end
    n_run++; if (leak !== 1'b0) begin n_fail++; $display("FAIL redir_drain: got %b want 0", leak); end
    wait_req(seen);
    n_run++; if (!seen || req_addr !== 64'h2000) begin n_fail++; $display("FAIL redir_req2: seen %b addr %h want 2000", seen, req_addr); end
    ack_req();
    send_beat(64'h2000, 0);
    n_run++; if (dec_avail !== 4'd0) begin n_fail++; $display("FAIL redir_skip_b0: got %0d want 0", dec_avail); end
    send_beat(64'h2000, 1);
    n_run++; if (dec_avail !== 4'd8) begin n_fail++; $display("FAIL redir_avail_b1: got %0d want 8", dec_avail); end
    n_run++; if (dec_bytes[7:0] !== 8'h08) begin n_fail++; $display("FAIL redir_byte0: got %h want 08", dec_bytes[7:0]); end
  endtask

  task automatic test_unaligned();
    logic seen;
    do_reset(64'h1013);
    n_run++; if (dec_rip !== 64'h1013) begin n_fail++; $display("FAIL unal_reset_rip: got %h want 1013", dec_rip); end
    wait_req(seen);
    n_run++; if (!seen || req_addr !== 64'h1000) begin n_fail++; $display("FAIL unal_req: seen %b addr %h want 1000", seen, req_addr); end
    ack_req();
    send_beat(64'h1000, 0);
    send_beat(64'h1000, 1);
    n_run++; if (dec_avail !== 4'd0) begin n_fail++; $display("FAIL unal_avail_b1: got %0d want 0", dec_avail); end
    send_beat(64'h1000, 2);
    n_run++; if (dec_avail !== 4'd5) begin n_fail++; $display("FAIL unal_avail_b2: got %0d want 5", dec_avail); end
    n_run++; if (dec_bytes[7:0] !== 8'h13) begin n_fail++; $display("FAIL unal_byte0: got %h want 13", dec_bytes[7:0]); end
    send_beat(64'h1000, 3);
    n_run++; if (dec_avail !== 4'd13) begin n_fail++; $display("FAIL unal_avail_b3: got %0d want 13", dec_avail); end
    send_beat(64'h1000, 4);
    n_run++; if (dec_bytes !== exp_window(64'h1013)) begin n_fail++; $display("FAIL unal_window: got %h want %h", dec_bytes, exp_window(64'h1013)); end
    for (int k = 5; k < 8; k++) send_beat(64'h1000, k);
    wait_req(seen);
    n_run++; if (!seen || req_addr !== 64'h1040) begin n_fail++; $display("FAIL unal_req2: seen %b addr %h want 1040", seen, req_addr); end
    ack_req();
    send_beat(64'h1040, 0);
    consume(15); consume(15); consume(15);
    n_run++; if (dec_avail !== 4'd8) begin n_fail++; $display("FAIL unal_avail_line2: got %0d want 8", dec_avail); end
    n_run++; if (dec_bytes[7:0] !== 8'h40 || dec_rip !== 64'h1040) begin n_fail++; $display("FAIL unal_line2_head: got %h@%h want 40@1040", dec_bytes[7:0], dec_rip); end
  endtask

  task automatic test_async_reset();
    logic seen;
    do_reset(64'h1000);
    wait_req(seen);
    ack_req();
    send_beat(64'h1000, 0);
    send_beat(64'h1000, 1);
    n_run++; if (dec_avail !== 4'd15) begin n_fail++; $display("FAIL areset_pre_avail: got %0d want 15", dec_avail); end
    entry = 64'h3000;
    #2;
    reset_n = 1'b0;
    #2;
    n_run++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL areset_req_valid: got %b want 0", req_valid); end
    n_run++; if (dec_avail !== 4'd0) begin n_fail++; $display("FAIL areset_avail: got %0d want 0", dec_avail); end
    n_run++; if (dec_rip !== 64'h3000) begin n_fail++; $display("FAIL areset_rip: got %h want 3000", dec_rip); end
    n_run++; if (req_addr !== 64'h0) begin n_fail++; $display("FAIL areset_req_addr: got %h want 0", req_addr); end
    repeat (2) tick();
    reset_n = 1'b1;
    wait_req(seen);
    n_run++; if (!seen || req_addr !== 64'h3000) begin n_fail++; $display("FAIL areset_restart: seen %b addr %h want 3000", seen, req_addr); end
    ack_req();
    send_beat(64'h3000, 0);
    send_beat(64'h3000, 1);
    n_run++; if (dec_bytes !== exp_window(64'h3000)) begin n_fail++; $display("FAIL areset_window: got %h want %h", dec_bytes, exp_window(64'h3000)); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_backpressure();
    test_wrap();
    test_redirect();
    test_unaligned();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
